axi_aw_allocator_rr: RTL

- Write-address allocator for one master (slave-side) port of the AXI node.
- Round-robin arbitrates the AW channels of N_TARG_PORT target ports onto a single AW output.
- On each accepted AW it pushes the routing tag {BIN_ID, OH_ID} of the winner into the downstream write-data allocator's ID FIFO, so that W beats are later steered to the same port in AW order.
- It sits directly upstream of that write-data allocator; its push/tag/grant ports connect one-to-one to the allocator's push_ID_i / ID_i / grant_FIFO_ID_o.

---
 rtl/axi_aw_allocator_rr.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/axi_aw_allocator_rr.sv
// Round-robin AW allocator: merges N_TARG_PORT write-address channels onto one
// slave-facing AW port and pushes the winner's {BIN_ID, OH_ID} tag to the W allocator.
module axi_aw_allocator_rr #(
   parameter int AXI_ADDRESS_W = 32,
   parameter int AXI_USER_W    = 6,
   parameter int AXI_ID_IN     = 16,
   parameter int N_TARG_PORT   = 7,
   parameter int LOG_N_TARG    = $clog2(N_TARG_PORT)
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]        awid_i,
   input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0]    awaddr_i,
   input  logic [N_TARG_PORT-1:0][7:0]                  awlen_i,
   input  logic [N_TARG_PORT-1:0][2:0]                  awsize_i,
   input  logic [N_TARG_PORT-1:0][1:0]                  awburst_i,
   input  logic [N_TARG_PORT-1:0]                       awlock_i,
   input  logic [N_TARG_PORT-1:0][3:0]                  awcache_i,
   input  logic [N_TARG_PORT-1:0][2:0]                  awprot_i,
   input  logic [N_TARG_PORT-1:0][3:0]                  awregion_i,
   input  logic [N_TARG_PORT-1:0][3:0]                  awqos_i,
   input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]       awuser_i,
   input  logic [N_TARG_PORT-1:0]                       awvalid_i,
   output logic [N_TARG_PORT-1:0]                       awready_o,
   output logic [AXI_ID_IN-1:0]                         awid_o,
   output logic [AXI_ADDRESS_W-1:0]                     awaddr_o,
   output logic [7:0]                                   awlen_o,
   output logic [2:0]                                   awsize_o,
   output logic [1:0]                                   awburst_o,
   output logic                                         awlock_o,
   output logic [3:0]                                   awcache_o,
   output logic [2:0]                                   awprot_o,
   output logic [3:0]                                   awregion_o,
   output logic [3:0]                                   awqos_o,
   output logic [AXI_USER_W-1:0]                        awuser_o,
   output logic                                         awvalid_o,
   input  logic                                         awready_i,
   output logic                                         push_ID_o,
   output logic [LOG_N_TARG+N_TARG_PORT-1:0]            ID_o,
   input  logic                                         grant_FIFO_ID_i
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [LOG_N_TARG-1:0]   rr_ptr_q, rr_ptr_d;
   logic [LOG_N_TARG-1:0]   lock_q, lock_d;
   logic [LOG_N_TARG-1:0]   win_s;
   logic                    found_s;
   logic [LOG_N_TARG-1:0]   sel_s;
   logic [N_TARG_PORT-1:0]  oh_s;
   logic                    req_ok_s;

   function automatic logic [LOG_N_TARG-1:0] wrap_add(input logic [LOG_N_TARG-1:0] base,
                                                      input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= 32'(N_TARG_PORT)) begin
         s = s - 32'(N_TARG_PORT);
      end else begin
         s = s;
      end
      return LOG_N_TARG'(s);
   endfunction

   // first requesting port at or after rr_ptr_q, wrapping around
   always_comb begin
      win_s   = rr_ptr_q;
      found_s = 1'b0;
      for (int k = 0; k < N_TARG_PORT; k++) begin
         if (!found_s && awvalid_i[wrap_add(rr_ptr_q, k)]) begin
            win_s   = wrap_add(rr_ptr_q, k);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // grant index is frozen while LOCKED so the slave sees a stable payload
   always_comb begin
      sel_s = (state_q == LOCKED) ? lock_q : win_s;
      oh_s  = '0;
      oh_s[sel_s] = 1'b1;
   end

   assign req_ok_s = grant_FIFO_ID_i & found_s;

   assign awid_o     = awid_i[sel_s];
   assign awaddr_o   = awaddr_i[sel_s];
   assign awlen_o    = awlen_i[sel_s];
   assign awsize_o   = awsize_i[sel_s];
   assign awburst_o  = awburst_i[sel_s];
   assign awlock_o   = awlock_i[sel_s];
   assign awcache_o  = awcache_i[sel_s];
   assign awprot_o   = awprot_i[sel_s];
   assign awregion_o = awregion_i[sel_s];
   assign awqos_o    = awqos_i[sel_s];
   assign awuser_o   = awuser_i[sel_s];
   assign ID_o       = {sel_s, oh_s};

   // state, pointer and locked-index registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         lock_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         lock_q   <= lock_d;
      end
   end

   // next-state: pointer only moves on a completed handshake
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      lock_d   = lock_q;
      case (state_q)
         IDLE: begin
            if (req_ok_s && awready_i) begin
               rr_ptr_d = wrap_add(win_s, 1);
            end else if (req_ok_s) begin
               state_d = LOCKED;
               lock_d  = win_s;
            end else begin
               state_d = IDLE;
            end
         end
         LOCKED: begin
            // FIFO slot checked at lock time cannot be taken by anyone else
            if (awvalid_i[lock_q] && awready_i) begin
               state_d  = IDLE;
               rr_ptr_d = wrap_add(lock_q, 1);
            end else begin
               state_d = LOCKED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // handshake outputs, forced quiet while reset is asserted
   always_comb begin
      awvalid_o = 1'b0;
      awready_o = '0;
      push_ID_o = 1'b0;
      if (rst) begin
         awvalid_o = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_ok_s) begin
                  awvalid_o = 1'b1;
                  awready_o = oh_s & {N_TARG_PORT{awready_i}};
                  push_ID_o = awready_i;
               end else begin
                  awvalid_o = 1'b0;
               end
            end
            LOCKED: begin
               awvalid_o = awvalid_i[lock_q];
               awready_o = oh_s & {N_TARG_PORT{awready_i}};
               push_ID_o = awvalid_i[lock_q] & awready_i;
            end
            default: begin
               awvalid_o = 1'b0;
            end
         endcase
      end
   end

endmodule
